// File: rtl/vga_scan_pkg.sv
// Shared raster timing defaults, game-state codes and colour types for the VGA scan path.
// Also provides the test-bar colour helper used when VGA_TEST_PATTERN_EN is defined.
package vga_scan_pkg;

  localparam int CNT_W = 10;

  localparam logic [1:0] WAITING   = 2'd0;
  localparam logic [1:0] COUNTDOWN = 2'd1;
  localparam logic [1:0] SUCCESS   = 2'd2;
  localparam logic [1:0] FAILURE   = 2'd3;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam int DEF_PIX_SHIFT = 3;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // Widen by replicating the MSBs so full-scale 332 maps to full-scale 444.
  function automatic rgb444_t rgb332_to_rgb444(input rgb332_t c);
    rgb444_t o;
    o.r = {c.r, c.r[2]};
    o.g = {c.g, c.g[2]};
    o.b = {c.b, c.b};
    return o;
  endfunction

  function automatic rgb332_t test_bar_color(input logic [6:0] x);
    logic [2:0] bar;
    rgb332_t    o;
    bar = 3'(x / 7'd10);
    o.r = bar[2] ? 3'd7 : 3'd0;
    o.g = bar[1] ? 3'd7 : 3'd0;
    o.b = bar[0] ? 2'd3 : 2'd0;
    return o;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster h/v counters advancing on the pixel-clock enable, with sync and visible-window decode.
// Sync and visibility outputs are combinational from the registered counters.
module vga_timing_gen
  import vga_scan_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_ce_i,
  output logic [CNT_W-1:0] h_cnt_o,
  output logic [CNT_W-1:0] v_cnt_o,
  output logic             hs_n_o,
  output logic             vs_n_o,
  output logic             h_vis_o,
  output logic             v_vis_o,
  output logic             vis_o
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] H_MAX_C  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [CNT_W-1:0] HS_BEG_C = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END_C = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] V_MAX_C  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [CNT_W-1:0] VS_BEG_C = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END_C = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [CNT_W-1:0] h_cnt_d, h_cnt_q;
  logic [CNT_W-1:0] v_cnt_d, v_cnt_q;

  // Next raster position: the line counter steps only when the pixel counter wraps.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_ce_i) begin
      if (h_cnt_q == H_MAX_C) begin
        h_cnt_d = CNT_ZERO;
        if (v_cnt_q == V_MAX_C) begin
          v_cnt_d = CNT_ZERO;
        end else begin
          v_cnt_d = v_cnt_q + CNT_ONE;
        end
      end else begin
        h_cnt_d = h_cnt_q + CNT_ONE;
        v_cnt_d = v_cnt_q;
      end
    end else begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
    end
  end

  // Raster position registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q <= CNT_ZERO;
      v_cnt_q <= CNT_ZERO;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Sync pulses (active-low) and visible-window flags for the current position.
  always_comb begin
    hs_n_o  = 1'b1;
    vs_n_o  = 1'b1;
    h_vis_o = 1'b0;
    v_vis_o = 1'b0;
    if ((h_cnt_q >= HS_BEG_C) && (h_cnt_q <= HS_END_C)) begin
      hs_n_o = 1'b0;
    end else begin
      hs_n_o = 1'b1;
    end
    if ((v_cnt_q >= VS_BEG_C) && (v_cnt_q <= VS_END_C)) begin
      vs_n_o = 1'b0;
    end else begin
      vs_n_o = 1'b1;
    end
    if (h_cnt_q < H_VIS_C) begin
      h_vis_o = 1'b1;
    end else begin
      h_vis_o = 1'b0;
    end
    if (v_cnt_q < V_VIS_C) begin
      v_vis_o = 1'b1;
    end else begin
      v_vis_o = 1'b0;
    end
  end

  assign vis_o   = h_vis_o & v_vis_o;
  assign h_cnt_o = h_cnt_q;
  assign v_cnt_o = v_cnt_q;

endmodule

// File: rtl/vga_scan_driver.sv
// VGA scan driver: rasterises the 80x60 logical grid onto 640x480@60 with a one-tick colour/sync stage.
// Optional VGA_TEST_PATTERN_EN adds test_mode, which replaces renderer colour with eight vertical bars.
module vga_scan_driver
  import vga_scan_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int PIX_SHIFT = DEF_PIX_SHIFT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_ce,
  input  logic [1:0] state_in,
  input  logic [7:0] color_in,
`ifdef VGA_TEST_PATTERN_EN
  input  logic       test_mode,
`endif
  output logic [6:0] x,
  output logic [6:0] y,
  output logic [1:0] state,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       frame_start,
  output logic       active
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VISIBLE);

  logic [CNT_W-1:0] h_cnt_s;
  logic [CNT_W-1:0] v_cnt_s;
  logic             hs_n_s;
  logic             vs_n_s;
  logic             h_vis_s;
  logic             v_vis_s;
  logic             vis0_s;
  logic             at_origin_s;
  logic             at_vblank_s;
  rgb332_t          src_s;
  rgb332_t          pix_s;
  rgb444_t          dac_d, dac_q;
  logic             active_d, active_q;
  logic             hs_d, hs_q;
  logic             vs_d, vs_q;
  logic [1:0]       state_d, state_q;

  vga_timing_gen #(
    .H_VISIBLE (H_VISIBLE),
    .H_FRONT   (H_FRONT),
    .H_SYNC    (H_SYNC),
    .H_BACK    (H_BACK),
    .V_VISIBLE (V_VISIBLE),
    .V_FRONT   (V_FRONT),
    .V_SYNC    (V_SYNC),
    .V_BACK    (V_BACK)
  ) u_timing (
    .clk      (clk),
    .rst      (rst),
    .pix_ce_i (pix_ce),
    .h_cnt_o  (h_cnt_s),
    .v_cnt_o  (v_cnt_s),
    .hs_n_o   (hs_n_s),
    .vs_n_o   (vs_n_s),
    .h_vis_o  (h_vis_s),
    .v_vis_o  (v_vis_s),
    .vis_o    (vis0_s)
  );

  assign at_origin_s = (h_cnt_s == CNT_ZERO) && (v_cnt_s == CNT_ZERO);
  assign at_vblank_s = (h_cnt_s == CNT_ZERO) && (v_cnt_s == V_VIS_C);
  assign frame_start = pix_ce & ~rst & at_origin_s;

  // Logical grid address for the renderer; parked at zero outside the visible window.
  always_comb begin
    x = 7'd0;
    y = 7'd0;
    if (h_vis_s) begin
      x = 7'(h_cnt_s >> PIX_SHIFT);
    end else begin
      x = 7'd0;
    end
    if (v_vis_s) begin
      y = 7'(v_cnt_s >> PIX_SHIFT);
    end else begin
      y = 7'd0;
    end
  end

  // Colour source selection, blanked to black outside the visible window.
  always_comb begin
    src_s = rgb332_t'(color_in);
`ifdef VGA_TEST_PATTERN_EN
    if (test_mode) begin
      src_s = test_bar_color(x);
    end else begin
      src_s = rgb332_t'(color_in);
    end
`endif
    if (vis0_s) begin
      pix_s = src_s;
    end else begin
      pix_s = '{r: 3'd0, g: 3'd0, b: 2'd0};
    end
  end

  // Output stage: colour and syncs share one pipeline tick; state latches at the top of vblank.
  always_comb begin
    dac_d    = dac_q;
    active_d = active_q;
    hs_d     = hs_q;
    vs_d     = vs_q;
    state_d  = state_q;
    if (pix_ce) begin
      dac_d    = rgb332_to_rgb444(pix_s);
      active_d = vis0_s;
      hs_d     = hs_n_s;
      vs_d     = vs_n_s;
      if (at_vblank_s) begin
        state_d = state_in;
      end else begin
        state_d = state_q;
      end
    end else begin
      dac_d    = dac_q;
      active_d = active_q;
    end
  end

  // Output registers; syncs idle high out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dac_q    <= '{r: 4'd0, g: 4'd0, b: 4'd0};
      active_q <= 1'b0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      state_q  <= WAITING;
    end else begin
      dac_q    <= dac_d;
      active_q <= active_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      state_q  <= state_d;
    end
  end

  assign vga_r  = dac_q.r;
  assign vga_g  = dac_q.g;
  assign vga_b  = dac_q.b;
  assign active = active_q;
  assign vga_hs = hs_q;
  assign vga_vs = vs_q;
  assign state  = state_q;

endmodule

// File: tb/tb_vga_scan_driver.sv
// Randomised bench for vga_scan_driver against a raster-position model (tick count -> h/v by div/mod).
// Vertical timing is shortened so several complete frames fit in a short run; horizontal timing is default.
`timescale 1ns/1ps
module tb_vga_scan_driver;

  localparam int HV = 640;
  localparam int HF = 16;
  localparam int HS = 96;
  localparam int HB = 48;
  localparam int HT = HV + HF + HS + HB;
  localparam int VV = 16;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int VT = VV + VF + VS + VB;
  localparam int FT = HT * VT;

  logic       clk = 1'b0;
  logic       rst;
  logic       pix_ce;
  logic [1:0] state_in;
  logic [7:0] color_in;
  logic [7:0] color_rand;
  logic       rend_mode;
  logic       tmode;
  logic [6:0] x;
  logic [6:0] y;
  logic [1:0] state;
  logic [3:0] vga_r;
  logic [3:0] vga_g;
  logic [3:0] vga_b;
  logic       vga_hs;
  logic       vga_vs;
  logic       frame_start;
  logic       active;

  int n_vec = 0;
  int n_err = 0;
  int pos;
  logic [3:0] e_r, e_g, e_b;
  logic       e_act, e_hs, e_vs;
  logic [1:0] e_state;

  always #5 clk = ~clk;

  assign color_in = rend_mode ? {x[2:0], y[2:0], 2'b11} : color_rand;

  vga_scan_driver #(
    .V_VISIBLE (VV),
    .V_FRONT   (VF),
    .V_SYNC    (VS),
    .V_BACK    (VB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pix_ce      (pix_ce),
    .state_in    (state_in),
    .color_in    (color_in),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode   (tmode),
`endif
    .x           (x),
    .y           (y),
    .state       (state),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .frame_start (frame_start),
    .active      (active)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pos     = 0;
    e_r     = 4'd0;
    e_g     = 4'd0;
    e_b     = 4'd0;
    e_act   = 1'b0;
    e_hs    = 1'b1;
    e_vs    = 1'b1;
    e_state = 2'd0;
  endtask

  task automatic check_reset_vals();
    check_eq("rst_r",     32'(vga_r),       32'd0);
    check_eq("rst_g",     32'(vga_g),       32'd0);
    check_eq("rst_b",     32'(vga_b),       32'd0);
    check_eq("rst_act",   32'(active),      32'd0);
    check_eq("rst_hs",    32'(vga_hs),      32'd1);
    check_eq("rst_vs",    32'(vga_vs),      32'd1);
    check_eq("rst_state", 32'(state),       32'd0);
    check_eq("rst_x",     32'(x),           32'd0);
    check_eq("rst_y",     32'(y),           32'd0);
    check_eq("rst_fs",    32'(frame_start), 32'd0);
  endtask

  task automatic check_regs();
    check_eq("vga_r",  32'(vga_r),  32'(e_r));
    check_eq("vga_g",  32'(vga_g),  32'(e_g));
    check_eq("vga_b",  32'(vga_b),  32'(e_b));
    check_eq("active", 32'(active), 32'(e_act));
    check_eq("vga_hs", 32'(vga_hs), 32'(e_hs));
    check_eq("vga_vs", 32'(vga_vs), 32'(e_vs));
    check_eq("state",  32'(state),  32'(e_state));
  endtask

  // One clk: drive at the falling edge, check combinational outputs, advance the model, check registers.
  task automatic cycle(input logic ce);
    int         h, v, bar;
    logic [6:0] xm, ym;
    logic [7:0] c;
    logic       vis;
    pix_ce     = ce;
    color_rand = ($urandom_range(3) == 0) ? 8'hFF : 8'($urandom);
    h   = pos % HT;
    v   = pos / HT;
    vis = (h < HV) && (v < VV);
    xm  = (h < HV) ? 7'(h / 8) : 7'd0;
    ym  = (v < VV) ? 7'(v / 8) : 7'd0;
    c   = rend_mode ? {xm[2:0], ym[2:0], 2'b11} : color_rand;
`ifdef VGA_TEST_PATTERN_EN
    if (tmode) begin
      bar = int'(xm) / 10;
      c = {((bar & 4) != 0) ? 3'd7 : 3'd0, ((bar & 2) != 0) ? 3'd7 : 3'd0, ((bar & 1) != 0) ? 2'd3 : 2'd0};
    end
`else
    bar = 0;
`endif
    #1;
    check_eq("x",  32'(x),           32'(xm));
    check_eq("y",  32'(y),           32'(ym));
    check_eq("fs", 32'(frame_start), (ce && pos == 0) ? 32'd1 : 32'd0);
    @(posedge clk);
    if (ce) begin
      if (!vis) c = 8'h00;
      e_r   = {c[7:5], c[7]};
      e_g   = {c[4:2], c[4]};
      e_b   = {c[1:0], c[1:0]};
      e_act = vis;
      e_hs  = !((h >= HV + HF) && (h < HV + HF + HS));
      e_vs  = !((v >= VV + VF) && (v < VV + VF + VS));
      if (h == 0 && v == VV) e_state = state_in;
      pos = (pos + 1) % FT;
    end
    #1;
    check_regs();
    @(negedge clk);
  endtask

  initial begin
    rst        = 1'b1;
    pix_ce     = 1'b1;
    state_in   = 2'd0;
    color_rand = 8'h00;
    rend_mode  = 1'b1;
    tmode      = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_reset_vals();
    @(negedge clk);
    rst = 1'b0;

    // Full-rate frame with the x/y renderer; state_in flips mid-frame and must wait for vblank.
    for (int i = 0; i < 18000; i++) begin
      if (i == 5000) state_in = 2'd3;
      cycle(1'b1);
    end

    // Random colour (often all-ones) to expose any leak into blanking; occasional state changes.
    rend_mode = 1'b0;
    for (int i = 0; i < 18000; i++) begin
      if ($urandom_range(1999) == 0) state_in = 2'($urandom);
      cycle(1'b1);
    end

    // Half-rate enable.
    rend_mode = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      cycle(logic'(i % 2 == 0));
    end

    // Irregular enable with random colour and random test mode.
    rend_mode = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      if (i % 500 == 0) tmode = 1'($urandom);
      if ($urandom_range(999) == 0) state_in = 2'($urandom);
      cycle(logic'($urandom_range(3) != 0));
    end
    tmode = 1'b0;

    // Asynchronous reset mid-frame: outputs clear before the next clock edge.
    pix_ce = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      cycle(1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
